hidden_row_feeder: RTL and testbench

- Drives the hidden-layer matrix accumulator that consumes `pixel`, `load` and a 100-lane `add` row.
- Sequences a 784-pixel binary image stream and fetches the matching weight row from the weight ROM for each pixel.
- Issues one load per set pixel, then signals `complete` when the image is exhausted.
- Sits between the image capture stream and the accumulator; it is the initiator side of the accumulator's load interface.

---
 rtl/hidden_row_feeder.sv | 151 +++++++++++++++
 tb/tb_hidden_row_feeder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hidden_row_feeder.sv
// hidden_row_feeder
//   Walks a binary image stream of N_PIXELS pixels. For every set pixel it
//   fetches the matching weight row from a synchronous ROM and hands it to
//   the hidden-layer accumulator as a one-cycle load. A complete pulse
//   follows the last pixel.
//
// Ports
//   clk, reset     rising-edge clock, asynchronous active-low reset
//   start          begins an image (honoured only when idle)
//   pix_valid/pix_data/pix_ready   pixel stream handshake
//   rom_addr/rom_q weight ROM row address and row data (1-cycle read)
//   acc_clear      clears the accumulator at the start of an image
//   load/pixel/add_row   accumulate strobe, pixel value and weight row
//   complete       image finished
//   busy           feeder is working on an image
//   ones_cnt       number of loads issued for the current/last image
module hidden_row_feeder #(
    parameter int unsigned N_PIXELS = 784,
    parameter int unsigned N_LANES  = 100,
    parameter int unsigned W        = 16,
    parameter int unsigned AW       = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   pix_valid,
    input  logic                   pix_data,
    output logic                   pix_ready,
    output logic [AW-1:0]          rom_addr,
    input  logic [N_LANES*W-1:0]   rom_q,
    output logic                   acc_clear,
    output logic                   load,
    output logic                   pixel,
    output logic [N_LANES*W-1:0]   add_row,
    output logic                   complete,
    output logic                   busy,
    output logic [AW-1:0]          ones_cnt
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N_PIXELS - 1);
    localparam logic [AW-1:0] MAX_CNT  = AW'(N_PIXELS);
    localparam logic [AW-1:0] ONE      = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GET,
        S_WAIT,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic          last;

    // Current pixel is the final one of the image.
    assign last = (idx == LAST_IDX);

    // Sequencer. pix_ready is high exactly while in GET; rom_addr is only
    // updated when entering or staying in GET, so the ROM row requested at
    // the accept edge is still on rom_q when ISSUE captures it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            rom_addr  <= '0;
            pix_ready <= 1'b0;
            acc_clear <= 1'b0;
            load      <= 1'b0;
            pixel     <= 1'b0;
            add_row   <= '0;
            complete  <= 1'b0;
            busy      <= 1'b0;
            ones_cnt  <= '0;
        end else begin
            acc_clear <= 1'b0;
            load      <= 1'b0;
            pixel     <= 1'b0;
            complete  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_CLEAR;
                        idx       <= '0;
                        ones_cnt  <= '0;
                        acc_clear <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                S_CLEAR: begin
                    state     <= S_GET;
                    pix_ready <= 1'b1;
                    rom_addr  <= idx;
                end

                S_GET: begin
                    if (pix_valid && pix_ready) begin
                        if (pix_data) begin
                            state     <= S_WAIT;
                            pix_ready <= 1'b0;
                        end else if (last) begin
                            state     <= S_DONE;
                            pix_ready <= 1'b0;
                        end else begin
                            idx      <= idx + ONE;
                            rom_addr <= idx + ONE;
                        end
                    end
                end

                // ROM read of rom_addr is in flight.
                S_WAIT: begin
                    state <= S_ISSUE;
                end

                S_ISSUE: begin
                    load    <= 1'b1;
                    pixel   <= 1'b1;
                    add_row <= rom_q;
                    if (ones_cnt < MAX_CNT) begin
                        ones_cnt <= ones_cnt + ONE;
                    end
                    if (last) begin
                        state <= S_DONE;
                    end else begin
                        state     <= S_GET;
                        idx       <= idx + ONE;
                        rom_addr  <= idx + ONE;
                        pix_ready <= 1'b1;
                    end
                end

                S_DONE: begin
                    complete <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    state     <= S_IDLE;
                    pix_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hidden_row_feeder.sv
// Directed bench for hidden_row_feeder with a behavioural weight ROM.
module tb_hidden_row_feeder;

    localparam int unsigned N  = 784;
    localparam int unsigned NL = 100;
    localparam int unsigned W  = 16;
    localparam int unsigned AW = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              pix_valid = 1'b0;
    logic              pix_data = 1'b0;
    logic              pix_ready;
    logic [AW-1:0]     rom_addr;
    logic [NL*W-1:0]   rom_q = '0;
    logic              acc_clear;
    logic              load;
    logic              pixel;
    logic [NL*W-1:0]   add_row;
    logic              complete;
    logic              busy;
    logic [AW-1:0]     ones_cnt;

    hidden_row_feeder #(.N_PIXELS(N), .N_LANES(NL), .W(W), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .acc_clear(acc_clear), .load(load), .pixel(pixel), .add_row(add_row),
        .complete(complete), .busy(busy), .ones_cnt(ones_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ROM contents: mode 0 = every lane 1, mode 1 = row*4 + lane.
    int rom_mode = 0;

    function automatic int exp_lane(input int row, input int lane);
        return (rom_mode != 0) ? (row * 4 + lane) : 1;
    endfunction

    function automatic logic [NL*W-1:0] rom_row(input logic [AW-1:0] r);
        logic [NL*W-1:0] v;
        for (int i = 0; i < int'(NL); i++) begin
            v[i*W +: W] = W'(exp_lane(int'(r), i));
        end
        return v;
    endfunction

    always @(posedge clk) rom_q <= rom_row(rom_addr);

    // Posedge counter, read at negedges.
    int pc = 0;
    always @(posedge clk) pc <= pc + 1;

    typedef struct {
        int due;
        int row;
    } exp_t;
    exp_t q[$];
    exp_t e;

    int n_load, n_complete, n_clear, run_len, max_run, last_load_pc, complete_pc;

    // Output monitor: every load must match the oldest outstanding set pixel.
    always @(negedge clk) begin
        if (load) begin
            n_load++;
            last_load_pc = pc;
            if (q.size() == 0) begin
                check("load_unexpected", 64'(load), 64'd0);
            end else begin
                e = q.pop_front();
                check("load_latency", 64'(pc), 64'(e.due));
                check("load_pixel", 64'(pixel), 64'd1);
                check("lane0", 64'(add_row[0 +: W]), 64'(exp_lane(e.row, 0)));
                check("lane5", 64'(add_row[5*W +: W]), 64'(exp_lane(e.row, 5)));
                check("lane99", 64'(add_row[99*W +: W]), 64'(exp_lane(e.row, 99)));
            end
        end
        if (complete) begin
            n_complete++;
            complete_pc = pc;
        end
        if (acc_clear) n_clear++;
        if (pix_ready) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    function automatic logic pixf(input int pmode, input int i);
        case (pmode)
            0:       return 1'b1;
            1:       return 1'b0;
            default: return 1'(i % 2);
        endcase
    endfunction

    // One image: pmode selects the pixel pattern, gap is the idle percentage,
    // mid_start pulses start before pixel mid_start, reset_at aborts after
    // that many accepted pixels.
    task automatic run_image(input int pmode, input int gap, input int mid_start,
                             input int reset_at, input int exp_loads);
        int i, guard, last_acc_pc;
        bit mid_done;
        q.delete();
        n_load = 0; n_complete = 0; n_clear = 0; max_run = 0;
        last_load_pc = -1; complete_pc = -1; last_acc_pc = -1;
        i = 0; guard = 0; mid_done = 0;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("clear_pulse", 64'(acc_clear), 64'd1);
        check("ready_in_clear", 64'(pix_ready), 64'd0);
        check("busy_after_start", 64'(busy), 64'd1);

        while (i < int'(N) && guard < 20000) begin
            @(negedge clk);
            guard++;
            start = 1'b0;
            if (i == mid_start && !mid_done) begin
                start = 1'b1;
                mid_done = 1'b1;
            end
            pix_valid = (gap == 0) ? 1'b1 : ($urandom_range(0, 99) >= 32'(gap));
            pix_data  = pixf(pmode, i);
            if (pix_valid && pix_ready) begin
                if (pix_data) q.push_back('{pc + 3, i});
                last_acc_pc = pc + 2;
                i++;
                if (i == reset_at) break;
            end
        end
        if (guard >= 20000) check("stream_timeout", 64'(i), 64'(N));

        if (reset_at >= 0) begin
            @(posedge clk);
            #2 reset = 1'b0;
            #1;
            check("arst_busy", 64'(busy), 64'd0);
            check("arst_ready", 64'(pix_ready), 64'd0);
            check("arst_load", 64'(load), 64'd0);
            check("arst_ones", 64'(ones_cnt), 64'd0);
            check("arst_addr", 64'(rom_addr), 64'd0);
            check("arst_row", 64'(|add_row), 64'd0);
            check("arst_clear", 64'(acc_clear), 64'd0);
            start = 1'b0; pix_valid = 1'b0;
            repeat (2) @(negedge clk);
            reset = 1'b1;
            repeat (10) @(negedge clk);
            check("arst_no_complete", 64'(n_complete), 64'd0);
            check("arst_idle", 64'(busy), 64'd0);
            q.delete();
            return;
        end

        @(negedge clk);
        pix_valid = 1'b0;
        start = 1'b0;
        guard = 0;
        while (n_complete == 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        check("loads", 64'(n_load), 64'(exp_loads));
        check("completes", 64'(n_complete), 64'd1);
        check("ones_cnt", 64'(ones_cnt), 64'(exp_loads));
        check("clears", 64'(n_clear), 64'd1);
        check("busy_idle", 64'(busy), 64'd0);
        check("pending_loads", 64'(q.size()), 64'd0);
        if (pmode == 1) begin
            check("ready_run", 64'(max_run), 64'(N));
            check("zero_complete_time", 64'(complete_pc), 64'(last_acc_pc));
        end
        if (pmode == 0) begin
            check("complete_after_load", 64'(complete_pc), 64'(last_load_pc + 1));
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(pix_ready), 64'd0);
        check("rst_load", 64'(load), 64'd0);
        check("rst_complete", 64'(complete), 64'd0);
        check("rst_ones", 64'(ones_cnt), 64'd0);
        check("rst_addr", 64'(rom_addr), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        rom_mode = 0; run_image(0, 0, -1, -1, 784);   // all ones
        rom_mode = 0; run_image(1, 0, -1, -1, 0);     // all zeros
        rom_mode = 1; run_image(2, 0, -1, -1, 392);   // odd pixels, address tracking
        rom_mode = 1; run_image(2, 30, -1, -1, 392);  // same image with stream gaps
        rom_mode = 1; run_image(0, 0, 100, -1, 784);  // start while busy
        rom_mode = 0; run_image(0, 0, -1, 300, 0);    // reset mid-image
        rom_mode = 0; run_image(0, 0, -1, -1, 784);   // clean image after reset

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
